// File: rtl/rtc_bcd_core.sv
// rtc_bcd_core
//   HH:MM:SS timekeeping core in packed BCD for the seven-segment driver.
//   clk_sys is divided by TICK_DIV into a 1 Hz tick that advances the time.
//   The control FSM can load a full time or nudge single fields. Per-second
//   and midnight-wrap pulses are provided for the alarm/countdown logic.
//
// Optional feature: define RTC_ALARM_MATCH_EN to add an HH:MM alarm compare.
//
// Ports
//   clk_sys     in   system clock
//   rstn        in   asynchronous active-low reset
//   run_en      in   1 = prescaler runs; 0 = prescaler and time frozen
//   load        in   pulse; load load_data if it is a legal time
//   load_data   in   [19:0] packed BCD, same layout as time_data
//   inc_hour    in   pulse; hours +1 (23 -> 00)
//   inc_min     in   pulse; minutes +1 (59 -> 00), no carry into hours
//   clr_sec     in   pulse; seconds -> 00 and prescaler -> 0
//   time_data   out  [3:0] s1, [6:4] s10, [10:7] m1, [13:11] m10,
//                    [17:14] h1, [19:18] h10
//   sec_tick    out  pulse on each prescaler wrap, aligned with new time
//   day_wrap    out  pulse when a tick moves 23:59:59 -> 00:00:00
//   load_err    out  pulse when a load is rejected
//   alarm_arm   in   (RTC_ALARM_MATCH_EN) enable alarm compare
//   alarm_time  in   (RTC_ALARM_MATCH_EN) [12:0] HH:MM, layout of time_data[19:7]
//   alarm_hit   out  (RTC_ALARM_MATCH_EN) pulse when a tick reaches HH:MM:00
module rtc_bcd_core #(
  parameter int TICK_DIV = 100_000_000,
  parameter int PW       = 27
) (
  input  logic        clk_sys,
  input  logic        rstn,
  input  logic        run_en,
  input  logic        load,
  input  logic [19:0] load_data,
  input  logic        inc_hour,
  input  logic        inc_min,
  input  logic        clr_sec,
  output logic [19:0] time_data,
  output logic        sec_tick,
  output logic        day_wrap,
  output logic        load_err
`ifdef RTC_ALARM_MATCH_EN
  ,
  input  logic        alarm_arm,
  input  logic [12:0] alarm_time,
  output logic        alarm_hit
`endif
);

  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

  logic [3:0]    sec_o;
  logic [2:0]    sec_t;
  logic [3:0]    min_o;
  logic [2:0]    min_t;
  logic [3:0]    hr_o;
  logic [1:0]    hr_t;
  logic [PW-1:0] presc;

  logic          tick;
  logic          adj;
  logic          sec_carry;
  logic          min_carry;
  logic          midnight;
  logic          load_ok;
  logic [6:0]    adv_sec;
  logic [6:0]    adv_min;
  logic [5:0]    adv_hr;
  logic [6:0]    adj_sec;
  logic [6:0]    adj_min;
  logic [5:0]    adj_hr;

  // Base-60 BCD increment for a {tens[2:0], ones[3:0]} pair.
  function automatic logic [6:0] inc60(input logic [2:0] t, input logic [3:0] o);
    if (o == 4'd9) begin
      if (t == 3'd5) inc60 = 7'd0;
      else           inc60 = {t + 3'd1, 4'd0};
    end else begin
      inc60 = {t, o + 4'd1};
    end
  endfunction

  // 24-hour BCD increment for a {tens[1:0], ones[3:0]} pair.
  function automatic logic [5:0] inc24(input logic [1:0] t, input logic [3:0] o);
    if (t == 2'd2 && o == 4'd3) inc24 = 6'd0;
    else if (o == 4'd9)         inc24 = {t + 2'd1, 4'd0};
    else                        inc24 = {t, o + 4'd1};
  endfunction

  always_comb begin
    tick      = run_en && (presc == PRESC_LAST);
    adj       = inc_hour | inc_min | clr_sec;

    sec_carry = (sec_t == 3'd5) && (sec_o == 4'd9);
    min_carry = (min_t == 3'd5) && (min_o == 4'd9);
    midnight  = sec_carry && min_carry && (hr_t == 2'd2) && (hr_o == 4'd3);

    adv_sec   = inc60(sec_t, sec_o);
    adv_min   = sec_carry ? inc60(min_t, min_o) : {min_t, min_o};
    adv_hr    = (sec_carry && min_carry) ? inc24(hr_t, hr_o) : {hr_t, hr_o};

    adj_sec   = clr_sec  ? 7'd0 : {sec_t, sec_o};
    adj_min   = inc_min  ? inc60(min_t, min_o) : {min_t, min_o};
    adj_hr    = inc_hour ? inc24(hr_t, hr_o)   : {hr_t, hr_o};

    load_ok   = (load_data[3:0]   <= 4'd9) &&
                (load_data[6:4]   <= 3'd5) &&
                (load_data[10:7]  <= 4'd9) &&
                (load_data[13:11] <= 3'd5) &&
                (load_data[17:14] <= 4'd9) &&
                (load_data[19:18] <= 2'd2) &&
                !((load_data[19:18] == 2'd2) && (load_data[17:14] > 4'd3));
  end

  assign time_data = {hr_t, hr_o, min_t, min_o, sec_t, sec_o};

  always_ff @(posedge clk_sys or negedge rstn) begin
    if (!rstn) begin
      sec_o    <= '0;
      sec_t    <= '0;
      min_o    <= '0;
      min_t    <= '0;
      hr_o     <= '0;
      hr_t     <= '0;
      presc    <= '0;
      sec_tick <= 1'b0;
      day_wrap <= 1'b0;
      load_err <= 1'b0;
`ifdef RTC_ALARM_MATCH_EN
      alarm_hit <= 1'b0;
`endif
    end else begin
      sec_tick <= 1'b0;
      day_wrap <= 1'b0;
      load_err <= 1'b0;
`ifdef RTC_ALARM_MATCH_EN
      alarm_hit <= 1'b0;
`endif
      if (load) begin
        // A load owns the whole cycle: adjusts and the tick are dropped, and
        // a rejected load leaves even the prescaler untouched.
        if (load_ok) begin
          {hr_t, hr_o, min_t, min_o, sec_t, sec_o} <= load_data;
          presc <= '0;
        end else begin
          load_err <= 1'b1;
        end
      end else begin
        if (clr_sec || tick) presc <= '0;
        else if (run_en)     presc <= presc + PW'(1);

        sec_tick <= tick && !clr_sec;

        if (adj) begin
          // Field adjusts swallow this cycle's one-second advance.
          {sec_t, sec_o} <= adj_sec;
          {min_t, min_o} <= adj_min;
          {hr_t, hr_o}   <= adj_hr;
        end else if (tick) begin
          {sec_t, sec_o} <= adv_sec;
          {min_t, min_o} <= adv_min;
          {hr_t, hr_o}   <= adv_hr;
          day_wrap       <= midnight;
`ifdef RTC_ALARM_MATCH_EN
          // New seconds are 00 exactly when the seconds field carries.
          alarm_hit      <= alarm_arm && sec_carry && ({adv_hr, adv_min} == alarm_time);
`endif
        end
      end
    end
  end

endmodule

// File: doc/rtc_bcd_core.md
Name: rtc_bcd_core

Overview:
- Timekeeping core that drives the 20-bit packed BCD `time_data` bus consumed by the seven-segment display driver.
- Divides `clk_sys` down to a 1 Hz tick and keeps HH:MM:SS in BCD.
- Supports full-time load from the control FSM and single-field adjust pulses (hour/minute increment, seconds clear).
- Emits per-second and midnight-wrap pulses for the alarm/countdown logic.

Parameters:
- TICK_DIV, 100_000_000, `clk_sys` cycles per second; must be >= 2. Benches use 4.
- PW, 27, prescaler counter width; must satisfy 2^PW >= TICK_DIV.

Ports:
- clk_sys  in  1  system clock
- rstn  in  1  asynchronous active-low reset
- run_en  in  1  1 = timekeeping runs; 0 = prescaler and time frozen
- load  in  1  single-cycle pulse; loads `load_data` into time
- load_data  in  20  packed BCD, same layout as `time_data`
- inc_hour  in  1  single-cycle pulse; hours +1, wraps 23->00
- inc_min  in  1  single-cycle pulse; minutes +1, wraps 59->00
- clr_sec  in  1  single-cycle pulse; seconds -> 00, prescaler -> 0
- time_data  out  20  [3:0] sec ones, [6:4] sec tens, [10:7] min ones, [13:11] min tens, [17:14] hour ones, [19:18] hour tens
- sec_tick  out  1  one-cycle pulse at each prescaler wrap
- day_wrap  out  1  one-cycle pulse when a tick advances 23:59:59 -> 00:00:00
- load_err  out  1  one-cycle pulse when a load is rejected

Behaviour:
- **Reset** (async, `rstn`=0): `time_data`=0 (00:00:00), prescaler=0, `sec_tick`=0, `day_wrap`=0, `load_err`=0. All outputs are registered.
- **Prescaler:**
  - Counts 0..TICK_DIV-1 only while `run_en`=1; holds its value while `run_en`=0.
  - On the edge where it is TICK_DIV-1 and `run_en`=1: it returns to 0, `sec_tick`=1 on the following cycle, and time advances by one second in that same edge.
  - Time updates in the same edge as the prescaler wrap; `sec_tick` is asserted coincident with the updated `time_data`.
- **Advance carry chain:**
  - sec ones 9->0 carries to sec tens; sec tens 5->0 carries to min ones.
  - min ones 9->0 carries to min tens; min tens 5->0 carries to hours.
  - Hours are BCD 00..23: 09->10, 19->20, 23->00. The 23:59:59 -> 00:00:00 transition sets `day_wrap`=1 for one cycle.
- **Load:**
  - Valid when sec ones<=9, sec tens<=5, min ones<=9, min tens<=5, hour ones<=9, hour tens<=2, and not (hour tens=2 and hour ones>3).
  - Valid load: `time_data` <= `load_data` and prescaler <= 0 next edge.
  - Invalid load: time and prescaler are unchanged; `load_err`=1 for one cycle.
- **Adjust:**
  - `inc_min` affects minute digits only; no carry into hours.
  - `inc_hour` affects hours only.
  - `clr_sec` zeroes the seconds digits and the prescaler.
  - Any combination of `inc_hour`, `inc_min` and `clr_sec` in the same cycle applies all of them.
- **Priority per edge:**
  - `load` first: when asserted, adjust pulses and the tick advance are ignored.
  - Adjust pulses second: when any is asserted, the tick's one-second advance is discarded. `sec_tick` still pulses unless `clr_sec` reset the prescaler that cycle; `day_wrap` does not fire.
  - Tick advance last.
- **Run control:** `load` and adjust pulses act regardless of `run_en`.
- **Reset mid-operation:** immediate return to the reset state; no pending pulse survives.

Optional Feature:
- Macro: `RTC_ALARM_MATCH_EN`.
- When defined, adds ports:
  - `alarm_arm` in 1
  - `alarm_time` in 13 (packed HH:MM, same layout as `time_data[19:7]`)
  - `alarm_hit` out 1, reset 0
- `alarm_hit` is a one-cycle pulse, coincident with `sec_tick`, when `alarm_arm`=1 and a tick advance makes `time_data` equal to `alarm_time` with seconds 00.
- Loads and adjusts that land on the alarm time do not fire `alarm_hit`.
- When the macro is undefined, these ports and their logic are absent; all other behaviour is identical.

Test Plan (TICK_DIV=4):
- Reset, then `run_en`=1 for 40 cycles -> `sec_tick` every 4th cycle, `time_data` = 00:00:10 (0x00010).
- Load 23:59:58, `run_en`=1 -> after 2 ticks `time_data`=0, with one `day_wrap` pulse on the second tick.
- Load 09:59:59, one tick -> 10:00:00. Load 19:59:59, one tick -> 20:00:00.
- Load hour tens=2, hour ones=4 (24:00:00) -> `load_err` pulse, time unchanged. Load sec tens=6 -> same.
- At 12:59:30: `inc_min` -> 12:00:30 (no hour carry). `inc_hour` at 23:xx -> 00:xx. `clr_sec` on a tick cycle -> seconds 00, prescaler restarts, next `sec_tick` 4 cycles later.
- `load` and `inc_hour` in the same cycle -> load wins. `run_en`=0 for 20 cycles -> no `sec_tick`, time frozen. Assert `rstn` low mid-count -> all outputs 0 immediately.
